// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard front end: frame FSM
// states, scan-code prefixes, the project key set and the event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [7:0] KEY_F     = 8'h2B;
  localparam logic [7:0] KEY_H     = 8'h33;
  localparam logic [7:0] KEY_T     = 8'h2C;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // Membership test against the key set; the E0 flag is deliberately not an
  // input because extended and plain variants are treated alike.
  function automatic logic in_key_set(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    case (code)
      KEY_F, KEY_H, KEY_T, KEY_UP,
      KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_ESC: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO. The head entry is read straight from the storage
// registers so the consumer sees it without a read-latency cycle. A push
// while full is ignored here unless a pop frees a slot in the same cycle;
// reporting the dropped event is left to the instantiating block.
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: filters the raw PS/2 clock, receives 11-bit
// frames with start/parity/stop checking and an inactivity timeout, folds
// E0/F0 prefixes into make/break events and queues accepted keys.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8,
  parameter int ACCEPT_ALL     = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2d,
  input  logic                          ps2c,
  input  logic                          rx_en,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [7:0]                    key_code,
  output logic                          key_ext,
  output logic                          key_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [FILTER_LEN-1:0] filt_sr;
  logic                  filt_clk;
  logic                  fall_tick;

  state_t                state;
  state_t                next_state;
  logic [10:0]           frame;
  logic [3:0]            bit_cnt;
  logic [TW-1:0]         timer;
  logic                  timeout;

  logic                  byte_ok;
  logic [7:0]            rx_byte;
  logic                  ext_pend;
  logic                  brk_pend;
  logic                  push_req;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  key_event_t            new_event;
  key_event_t            head_event;

  // A fall tick is the cycle where the filter is about to flip from 1 to 0.
  assign fall_tick = filt_clk && (filt_sr == '0);

  // Glitch filter: the filtered clock only changes once the whole window agrees.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_sr  <= '0;
      filt_clk <= 1'b0;
    end else begin
      filt_sr <= {filt_sr[FILTER_LEN-2:0], ps2c};
      if (&filt_sr)
        filt_clk <= 1'b1;
      else if (filt_sr == '0)
        filt_clk <= 1'b0;
    end
  end

  // Frame FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign timeout = (state == DATA) && !fall_tick && (timer == TIMEOUT_LAST);

  // Frame FSM next-state logic; rx_en only gates the start of a frame.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (fall_tick && rx_en) next_state = DATA;
      DATA: begin
        if (fall_tick && bit_cnt == 4'd1) next_state = CHECK;
        else if (timeout)                 next_state = IDLE;
      end
      CHECK: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Frame FSM outputs: frame checks in CHECK, timeout report in DATA.
  always_comb begin
    frame_err  = 1'b0;
    parity_err = 1'b0;
    byte_ok    = 1'b0;
    if (state == CHECK) begin
      frame_err  = frame[0] || !frame[10];
      parity_err = !(^frame[9:1]);
      byte_ok    = !frame_err && !parity_err;
    end else if (timeout) begin
      frame_err = 1'b1;
    end
  end

  // Bit shifter (LSB first) and remaining-bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame   <= '0;
      bit_cnt <= '0;
    end else if (fall_tick) begin
      if (state == IDLE && rx_en) begin
        frame   <= {ps2d, frame[10:1]};
        bit_cnt <= 4'd10;
      end else if (state == DATA) begin
        frame   <= {ps2d, frame[10:1]};
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  // Inactivity timer, restarted by every fall tick and idle outside DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         timer <= '0;
    else if (fall_tick || state != DATA) timer <= '0;
    else                                timer <= timer + 1'b1;
  end

  assign rx_byte = frame[8:1];

  // Prefix flags: remember E0/F0 until the key byte arrives; errors wipe them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (frame_err || parity_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_ok) begin
      if (rx_byte == PREFIX_EXT) begin
        ext_pend <= 1'b1;
      end else if (rx_byte == PREFIX_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  // Event formation and key-set filtering of completed key bytes.
  always_comb begin
    new_event.ext  = ext_pend;
    new_event.brk  = brk_pend;
    new_event.code = rx_byte;
    push_req = byte_ok && (rx_byte != PREFIX_EXT) && (rx_byte != PREFIX_BRK) &&
               ((ACCEPT_ALL != 0) || in_key_set(rx_byte));
  end

  assign fifo_pop  = key_valid && key_ready;
  assign fifo_push = push_req;
  assign overflow  = push_req && fifo_full && !fifo_pop;

  ps2_event_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (new_event),
    .pop   (fifo_pop),
    .dout  (head_event),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Head presentation, masked to zero while the FIFO is empty.
  always_comb begin
    key_valid = !fifo_empty;
    key_code  = fifo_empty ? 8'h00 : head_event.code;
    key_ext   = !fifo_empty && head_event.ext;
    key_break = !fifo_empty && head_event.brk;
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder. Two instances share the PS/2
// stimulus: one filtering against the key set, one accepting every key.
// Expected events are queued when a frame is sent and compared on pop.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FL    = 4;
  localparam int TO    = 500;
  localparam int FD    = 8;
  localparam int LOWC  = 20;
  localparam int HIGHC = 20;
  localparam int SETUP = 5;

  logic clk = 1'b0;
  logic reset_n, ps2d, ps2c, rx_en, key_ready;

  logic       key_valid, key_ext, key_break, parity_err, frame_err, overflow;
  logic [7:0] key_code;
  logic [3:0] fifo_count;
  logic       key_valid_all, key_ext_all, key_break_all, parity_err_all, frame_err_all, overflow_all;
  logic [7:0] key_code_all;
  logic [3:0] fifo_count_all;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .ACCEPT_ALL(0)) dut (
    .clk(clk), .reset(reset_n), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
    .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
    .key_ext(key_ext), .key_break(key_break), .fifo_count(fifo_count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
  );

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(FD), .ACCEPT_ALL(1)) dut_all (
    .clk(clk), .reset(reset_n), .ps2d(ps2d), .ps2c(ps2c), .rx_en(rx_en),
    .key_valid(key_valid_all), .key_ready(key_ready), .key_code(key_code_all),
    .key_ext(key_ext_all), .key_break(key_break_all), .fifo_count(fifo_count_all),
    .parity_err(parity_err_all), .frame_err(frame_err_all), .overflow(overflow_all)
  );

  // System clock.
  always #5 clk = ~clk;

  int cyc = 0;
  // Cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_all_q[$];
  int par_cnt = 0, frm_cnt = 0, ovf_cnt = 0, ovf_all_cnt = 0;
  int valid_cycles = 0, stop_cyc = 0, valid_cyc = -1;
  logic prev_valid = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input logic flip);
    return {1'b1, (~^code) ^ flip, code, 1'b0};
  endfunction

  // Drives the first nbits of a frame, LSB first, with a slow PS/2 clock.
  task automatic applyStimulus(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1;
      ps2d = bits[i];
      repeat (SETUP) @(posedge clk);
      #1;
      ps2c = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (LOWC) @(posedge clk);
      #1;
      ps2c = 1'b1;
      repeat (HIGHC) @(posedge clk);
    end
    #1;
    ps2d = 1'b1;
  endtask

  task automatic send_key(input logic [7:0] code, input logic to_dut, input logic to_all,
                          input logic ext, input logic brk, input logic flip);
    if (to_dut) exp_q.push_back({ext, brk, code});
    if (to_all) exp_all_q.push_back({ext, brk, code});
    applyStimulus(make_frame(code, flip), 11);
    repeat (HIGHC) @(posedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_all_q.size() != 0); i++)
      @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checkOutput(tag, exp_q.size() + exp_all_q.size(), 0);
  endtask

  // Scoreboard and pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    logic [9:0] exp_ev;
    if (reset_n) begin
      if (parity_err)   par_cnt++;
      if (frame_err)    frm_cnt++;
      if (overflow)     ovf_cnt++;
      if (overflow_all) ovf_all_cnt++;
      if (key_valid) valid_cycles++;
      if (key_valid && !prev_valid && valid_cyc < 0) valid_cyc = cyc;
      if (key_valid && key_ready) begin
        if (exp_q.size() == 0) checkOutput("dut_unexpected_event", exp_q.size(), 1);
        else begin
          exp_ev = exp_q.pop_front();
          checkOutput("dut_event", {22'd0, key_ext, key_break, key_code}, {22'd0, exp_ev});
        end
      end
      if (key_valid_all && key_ready) begin
        if (exp_all_q.size() == 0) checkOutput("all_unexpected_event", exp_all_q.size(), 1);
        else begin
          exp_ev = exp_all_q.pop_front();
          checkOutput("all_event", {22'd0, key_ext_all, key_break_all, key_code_all}, {22'd0, exp_ev});
        end
      end
    end
    prev_valid = key_valid;
  end

  // Global time limit.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0, f0, o0, oa0;
    logic [7:0] codes [9];
    codes = '{8'h2B, 8'h33, 8'h2C, 8'h75, 8'h74, 8'h6B, 8'h72, 8'h76, 8'h2B};

    reset_n = 1'b0; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b0; key_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_valid", key_valid, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_code", key_code, 0);
    checkOutput("rst_flags", {key_ext, key_break, parity_err, frame_err, overflow}, 0);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rx_en = 1'b1; key_ready = 1'b1;

    // Plain make code with latency and single-cycle valid.
    valid_cyc = -1; valid_cycles = 0;
    send_key(8'h75, 1, 1, 0, 0, 0);
    wait_drain("t1_drain");
    checkOutput("t1_latency", valid_cyc - stop_cyc, FL + 2);
    checkOutput("t1_valid_cycles", valid_cycles, 1);
    checkOutput("t1_count", fifo_count, 0);

    // Extended release: E0 F0 74 collapses into one event.
    applyStimulus(make_frame(8'hE0, 0), 11);
    applyStimulus(make_frame(8'hF0, 0), 11);
    send_key(8'h74, 1, 1, 1, 1, 0);
    wait_drain("t2_drain");

    // Key outside the set only reaches the accept-all instance.
    send_key(8'h1C, 0, 1, 0, 0, 0);
    wait_drain("t3_drain");

    // Parity error discards the byte.
    p0 = par_cnt; f0 = frm_cnt;
    send_key(8'h2B, 0, 0, 0, 0, 1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t4_parity_pulse", par_cnt - p0, 1);
    checkOutput("t4_no_frame_err", frm_cnt - f0, 0);
    checkOutput("t4_count", fifo_count, 0);

    // Stalled frame times out, then a good frame is received.
    f0 = frm_cnt;
    applyStimulus(make_frame(8'h33, 0), 5);
    repeat (TO + 50) @(posedge clk);
    #1;
    checkOutput("t5_timeout_pulse", frm_cnt - f0, 1);
    send_key(8'h33, 1, 1, 0, 0, 0);
    wait_drain("t5_drain");

    // Overflow with consumer stalled, then ordered drain.
    key_ready = 1'b0;
    o0 = ovf_cnt; oa0 = ovf_all_cnt;
    for (int i = 0; i < 9; i++) send_key(codes[i], i < 8, i < 8, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t6_count_full", fifo_count, 8);
    checkOutput("t6_count_full_all", fifo_count_all, 8);
    checkOutput("t6_overflow", ovf_cnt - o0, 1);
    checkOutput("t6_overflow_all", ovf_all_cnt - oa0, 1);
    key_ready = 1'b1;
    wait_drain("t6_drain");
    checkOutput("t6_count_empty", fifo_count, 0);

    // Reset mid-frame with a queued event clears everything.
    key_ready = 1'b0;
    send_key(8'h2C, 0, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t7_count_before", fifo_count, 1);
    applyStimulus(make_frame(8'h76, 0), 4);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t7_rst_valid", key_valid, 0);
    checkOutput("t7_rst_count", fifo_count, 0);
    checkOutput("t7_rst_code", key_code, 0);
    checkOutput("t7_rst_flags", {key_ext, key_break, parity_err, frame_err, overflow}, 0);
    ps2c = 1'b1; ps2d = 1'b1;
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    key_ready = 1'b1;
    send_key(8'h76, 1, 1, 0, 0, 0);
    wait_drain("t7_drain");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Parametrised PS/2 keyboard front end: glitch-filters the PS/2 clock, receives 11-bit frames with full start/parity/stop checking and an inactivity timeout, and resolves E0/F0 prefixes into make/break key events. It also filters keys against the project key set and buffers events in a FIFO with a valid/ready handshake. It sits between the keyboard pins and the RTC controller's command logic.

## Interface
Parameters:
- FILTER_LEN, 8: PS/2 clock filter length in clk cycles (≥2).
- TIMEOUT_CYCLES, 100000: max clk cycles between falling edges inside a frame.
- FIFO_DEPTH, 8: event buffer depth, power of two, ≥2.
- ACCEPT_ALL, 0: 1 = enqueue every key; 0 = only keys in the package key set.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- ps2d  in  1  PS/2 data, raw.
- ps2c  in  1  PS/2 clock, raw.
- rx_en  in  1  allows a new frame to start; checked only in IDLE.
- key_valid  out  1  FIFO not empty.
- key_ready  in  1  consumer accepts head event.
- key_code  out  8  head event scan code (second byte for extended keys).
- key_ext  out  1  head event was E0-prefixed.
- key_break  out  1  head event is a release (F0-prefixed).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held.
- parity_err  out  1  one-cycle pulse, bad parity.
- frame_err  out  1  one-cycle pulse, bad start/stop bit or timeout.
- overflow  out  1  one-cycle pulse, event dropped because FIFO full.

## Operation
- Filter: FILTER_LEN-bit shift register of ps2c. Filtered clock goes to 1 when all bits are 1 and to 0 when all bits are 0; otherwise it holds. A fall tick is filtered 1→0.
- Frame FSM:
  - IDLE: on fall tick with rx_en, shift ps2d, set bit counter to 10, go to DATA.
  - DATA: each fall tick shifts ps2d; when 11 bits are held, go to CHECK.
  - CHECK: one cycle, then back to IDLE.
- Timeout counter clears on every fall tick. In DATA, reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err.
- Frame checks in CHECK (bits LSB-first: b0 start, b1–b8 data, b9 parity, b10 stop):
  - b0 must be 0 and b10 must be 1, else frame_err.
  - XOR of b1–b9 must be 1 (odd parity), else parity_err.
  - If both fail, both pulses fire in the same cycle.
  - Any error discards the byte and clears the prefix flags.
- Prefix decoder, on a good byte:
  - E0 sets ext_pend.
  - F0 sets brk_pend.
  - Any other byte forms the event {ext_pend, brk_pend, byte}, then both flags clear.
  - An event is enqueued if ACCEPT_ALL=1 or the byte is in the key set: 2B F, 33 H, 2C T, 75 up, 74 right, 6B left, 72 down, 76 ESC. The ext flag is ignored for set membership.
- FIFO:
  - Push of an event when the FIFO is full drops the event and pulses overflow.
  - Pop occurs when key_valid and key_ready are both high.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - Outputs show the head entry. When empty, key_code/key_ext/key_break are 0.
- Reset (any time, including mid-frame): FSM to IDLE; filter, counters, prefix flags and FIFO pointers cleared. All outputs 0.

## Timing
- Cycle N: fall tick for the stop bit, FSM in DATA. Cycle N+1: CHECK; error pulses fire here; push is written at the end of N+1. Cycle N+2: key_valid high.
- The filter adds FILTER_LEN cycles of latency from the raw ps2c edge to the fall tick.
- key_valid, outputs and fifo_count come from registers only. The pop takes effect on the clock edge where valid&ready are both high, and the next entry appears on the following cycle.
- rx_en low during DATA does not abort the frame.

## Structure
- Package ps2_pkg holds: FSM state enum (IDLE, DATA, CHECK), PREFIX_EXT=8'hE0, PREFIX_BRK=8'hF0, the eight key-set constants, and a 10-bit event typedef {ext, brk, code}.
- One sub-module, ps2_event_fifo: synchronous FIFO, width 10, depth FIFO_DEPTH, with full/empty/count and push/pop. Overflow detection lives in the top.

## Test plan
- Send make code 75 with good parity, key_ready=1 → one event code=75, ext=0, brk=0; key_valid high 2 cycles after the stop-bit tick, then low.
- Send E0 F0 74 → one event code=74, ext=1, brk=1; no event produced for E0 or F0.
- Send 1C (not in set) with ACCEPT_ALL=0 → no event; the same stimulus with ACCEPT_ALL=1 → event code=1C.
- Send 2B with the parity bit flipped → parity_err one pulse, no event. Send a frame that stalls after 5 bits → frame_err after TIMEOUT_CYCLES, FSM in IDLE; a following good 33 is received correctly.
- Hold key_ready=0 and send 9 accepted keys with FIFO_DEPTH=8 → fifo_count=8, one overflow pulse. Drain the FIFO → the first 8 codes come out in order.
- Assert reset mid-frame after 4 bits → all outputs 0. A new full frame 76 after release → event code=76.
